ps2_keyboard_rx: RTL and testbench

Receive-only PS/2 keyboard interface. It samples the raw PS/2 clock and data pins, deframes 11-bit device-to-host frames and checks their parity. Each good scan code is delivered as a one-cycle strobe plus data byte to the keyboard FIFO in the hardware-register block, through the `keyboard_code` and `keyboard_strobe` inputs of that block. Bad or stalled frames are dropped and flagged.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_keyboard_rx.sv | 131 +++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int PS2_DATA_BITS = 8;

    function automatic int timeout_cycles(input int clock_hz, input int timeout_us);
        return (clock_hz / 1_000_000) * timeout_us;
    endfunction

    function automatic int timeout_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 clock, debounces it with a run-length counter
// and emits a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             fall_q;
    logic             fall_d;

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= ps2_clk;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard deframer: start/data/parity/stop checking,
// inter-edge timeout, and a strobe per good scan code.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard_code,
    output logic       keyboard_strobe,
    output logic       frame_error
);

    localparam int TMO_CYCLES = timeout_cycles(CLOCK_HZ, TIMEOUT_US);
    localparam int TMO_W      = timeout_width(TMO_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYCLES);
    localparam int BIT_W      = $clog2(PS2_DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

    logic                     fall;
    logic                     data_sync1_q;
    logic                     data_sync2_q;
    ps2_state_t               state_q, state_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                     parity_q, parity_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [7:0]               code_q, code_d;
    logic                     strobe_q, strobe_d;
    logic                     error_q, error_d;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clock  (clock),
        .reset  (reset),
        .ps2_clk(ps2_clk),
        .fall   (fall)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        code_d    = code_q;
        strobe_d  = 1'b0;
        error_d   = 1'b0;
        tmo_d     = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (fall && !data_sync2_q) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_sync2_q, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_sync2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_sync2_q && (^{shift_q, parity_q})) begin
                        code_d   = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall in the same cycle as the limit takes priority over the timeout.
        if (state_q != IDLE && !fall && tmo_q == TMO_LIMIT) begin
            state_d = IDLE;
            tmo_d   = '0;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_sync1_q <= 1'b1;
            data_sync2_q <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            code_q       <= 8'h00;
            strobe_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            data_sync1_q <= ps2_data;
            data_sync2_q <= data_sync1_q;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            code_q       <= code_d;
            strobe_q     <= strobe_d;
            error_q      <= error_d;
        end
    end

    assign keyboard_code   = code_q;
    assign keyboard_strobe = strobe_q;
    assign frame_error     = error_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx; 1 MHz system clock so 1 cycle = 1 us.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyboard_code;
    logic       keyboard_strobe;
    logic       frame_error;

    ps2_keyboard_rx #(
        .CLOCK_HZ  (1_000_000),
        .FILTER_LEN(8),
        .TIMEOUT_US(2000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keyboard_code  (keyboard_code),
        .keyboard_strobe(keyboard_strobe),
        .frame_error    (frame_error)
    );

    always #500 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         s_cnt = 0;
    int         e_cnt = 0;
    int         both_cnt = 0;
    int         err_cyc = 0;
    int         last_fall_cyc = 0;
    logic [7:0] codes[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            if (keyboard_strobe) begin
                s_cnt <= s_cnt + 1;
                codes.push_back(keyboard_code);
            end
            if (frame_error) begin
                e_cnt   <= e_cnt + 1;
                err_cyc <= cyc;
            end
            if (keyboard_strobe && frame_error) both_cnt <= both_cnt + 1;
        end
    end

    initial begin
        repeat (50000) @(posedge clock);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] code, input logic par_flip,
                                               input logic stop_bit);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = code;
        f[9]   = (~^code) ^ par_flip;
        f[10]  = stop_bit;
        return f;
    endfunction

    // 40 us bit period: data changes 10 us before the clock falls, low for 20 us.
    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = f[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
    endtask

    int s0, e0, q0;

    task automatic mark();
        s0 = s_cnt;
        e0 = e_cnt;
        q0 = codes.size();
    endtask

    initial begin
        wait_cyc(5);
        check_eq("rst_code", 32'(keyboard_code), 32'h00);
        check_eq("rst_strobe", 32'(keyboard_strobe), 32'h0);
        check_eq("rst_error", 32'(frame_error), 32'h0);
        reset = 1'b1;
        wait_cyc(20);

        // Good 0x1C frame
        mark();
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
        wait_cyc(20);
        check_eq("good_strobes", 32'(s_cnt - s0), 32'd1);
        check_eq("good_errors", 32'(e_cnt - e0), 32'd0);
        check_eq("good_code", 32'(keyboard_code), 32'h1C);
        if (codes.size() > q0) check_eq("good_strobe_code", 32'(codes[q0]), 32'h1C);
        else check_eq("good_strobe_code", 32'(codes.size()), 32'(q0 + 1));

        // Parity error
        mark();
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 0, 10);
        wait_cyc(20);
        check_eq("par_strobes", 32'(s_cnt - s0), 32'd0);
        check_eq("par_errors", 32'(e_cnt - e0), 32'd1);
        check_eq("par_code_held", 32'(keyboard_code), 32'h1C);

        // Stop-bit error
        mark();
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 0, 10);
        wait_cyc(20);
        check_eq("stop_strobes", 32'(s_cnt - s0), 32'd0);
        check_eq("stop_errors", 32'(e_cnt - e0), 32'd1);
        check_eq("stop_code_held", 32'(keyboard_code), 32'h1C);

        // Timeout: start + 5 data bits then 2.5 ms of idle clock
        mark();
        send_bits(make_frame(8'h33, 1'b0, 1'b1), 0, 5);
        wait_cyc(2500);
        check_eq("tmo_errors", 32'(e_cnt - e0), 32'd1);
        check_eq("tmo_strobes", 32'(s_cnt - s0), 32'd0);
        check_eq("tmo_latency_ok",
                 32'((err_cyc - last_fall_cyc >= 2000) && (err_cyc - last_fall_cyc <= 2030)), 32'd1);
        mark();
        send_bits(make_frame(8'hF0, 1'b0, 1'b1), 0, 10);
        wait_cyc(20);
        check_eq("post_tmo_strobes", 32'(s_cnt - s0), 32'd1);
        check_eq("post_tmo_code", 32'(keyboard_code), 32'hF0);
        check_eq("post_tmo_errors", 32'(e_cnt - e0), 32'd0);

        // 3-cycle clock glitch in idle
        mark();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(100);
        check_eq("glitch_activity", 32'((s_cnt - s0) + (e_cnt - e0)), 32'd0);

        // Back-to-back frames, one idle bit period apart
        mark();
        send_bits(make_frame(8'hE0, 1'b0, 1'b1), 0, 10);
        wait_cyc(40);
        send_bits(make_frame(8'h74, 1'b0, 1'b1), 0, 10);
        wait_cyc(20);
        check_eq("b2b_strobes", 32'(s_cnt - s0), 32'd2);
        check_eq("b2b_errors", 32'(e_cnt - e0), 32'd0);
        if (codes.size() >= q0 + 2) begin
            check_eq("b2b_first", 32'(codes[q0]), 32'hE0);
            check_eq("b2b_second", 32'(codes[q0 + 1]), 32'h74);
        end else begin
            check_eq("b2b_codes", 32'(codes.size()), 32'(q0 + 2));
        end

        // Reset pulse after the 4th data bit, remainder of the frame still sent
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 4);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        mark();
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 5, 10);
        wait_cyc(20);
        check_eq("rstmid_strobes", 32'(s_cnt - s0), 32'd0);
        check_eq("rstmid_errors", 32'(e_cnt - e0), 32'd0);
        wait_cyc(2600);
        mark();
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 0, 10);
        wait_cyc(20);
        check_eq("after_rst_strobes", 32'(s_cnt - s0), 32'd1);
        check_eq("after_rst_code", 32'(keyboard_code), 32'h29);
        check_eq("after_rst_errors", 32'(e_cnt - e0), 32'd0);

        check_eq("strobe_error_exclusive", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
